// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Brief    : Parallel-to-serial pattern transmitter, MSB first, one bit per
//            clock, registered w/busy/frame_done, zero-gap back-to-back words.
//            Optional even-parity trailer bit: define SEQ_PATTERN_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
  parameter int   DATA_W   = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              w,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef SEQ_PATTERN_TX_PARITY_EN
    S_PAR   = 2'd2,
`endif
    S_SHIFT = 2'd1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [DATA_W-1:0]  r_sr,    w_sr_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic               r_w,     w_w_nxt;
  logic               r_busy,  w_busy_nxt;
  logic               r_fd,    w_fd_nxt;
  logic               w_accept;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic               r_par,   w_par_nxt;
`endif

  // Ready only where a new MSB can follow the current bit without a gap.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_IDLE:  in_ready = 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      S_PAR:   in_ready = 1'b1;
      S_SHIFT: in_ready = 1'b0;
`else
      S_SHIFT: in_ready = (r_cnt == '0);
`endif
      default: in_ready = 1'b0;
    endcase
    if (reset) in_ready = 1'b0;
  end

  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_w_nxt     = r_w;
    w_busy_nxt  = r_busy;
    w_fd_nxt    = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (w_accept) begin
      w_sr_nxt    = {in_data[DATA_W-2:0], 1'b0};
      w_w_nxt     = in_data[DATA_W-1];
      w_cnt_nxt   = c_cnt_last;
      w_busy_nxt  = 1'b1;
      w_state_nxt = S_SHIFT;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      w_par_nxt   = ^in_data;
`endif
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (r_cnt != '0) begin
            w_w_nxt   = r_sr[DATA_W-1];
            w_sr_nxt  = {r_sr[DATA_W-2:0], 1'b0};
            w_cnt_nxt = r_cnt - c_cnt_one;
`ifndef SEQ_PATTERN_TX_PARITY_EN
            // The LSB goes out next, so the pulse is raised to coincide with it.
            w_fd_nxt  = (r_cnt == c_cnt_one);
`endif
          end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
            w_w_nxt     = r_par;
            w_fd_nxt    = 1'b1;
            w_state_nxt = S_PAR;
`else
            w_w_nxt     = IDLE_LVL;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
`endif
          end
        end
`ifdef SEQ_PATTERN_TX_PARITY_EN
        S_PAR: begin
          w_w_nxt     = IDLE_LVL;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
`endif
        default: begin
          w_w_nxt     = IDLE_LVL;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_w     <= IDLE_LVL;
      r_busy  <= 1'b0;
      r_fd    <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_w     <= w_w_nxt;
      r_busy  <= w_busy_nxt;
      r_fd    <= w_fd_nxt;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign w          = r_w;
  assign busy       = r_busy;
  assign frame_done = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_tx
// Brief    : Self-checking bench for seq_pattern_tx against a bit-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

  localparam int   DATA_W   = 8;
  localparam logic IDLE_LVL = 1'b0;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              w;
  logic              busy;
  logic              frame_done;

  int n_checks = 0;
  int n_fails  = 0;

  // Bits still to appear on the line; front = bit currently on w.
  bit q_bit[$];
  bit q_last[$];

  seq_pattern_tx #(.DATA_W(DATA_W), .IDLE_LVL(IDLE_LVL)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .w(w), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready, advance model, check registered outputs.
  task automatic step(input logic rst_i, input logic vld_i, input logic [DATA_W-1:0] d_i,
                      output bit acc);
    @(negedge clk);
    reset = rst_i; in_valid = vld_i; in_data = d_i;
    #1;
    chk_val("in_ready", {31'd0, in_ready}, {31'd0, (!rst_i && q_bit.size() <= 1)});
    acc = 1'b0;
    if (rst_i) begin
      q_bit.delete(); q_last.delete();
    end else begin
      acc = vld_i && (q_bit.size() <= 1);
      if (q_bit.size() > 0) begin
        void'(q_bit.pop_front()); void'(q_last.pop_front());
      end
      if (acc) begin
        for (int i = DATA_W - 1; i >= 0; i--) begin
          q_bit.push_back(d_i[i]);
          q_last.push_back(1'b0);
        end
`ifdef SEQ_PATTERN_TX_PARITY_EN
        q_bit.push_back(^d_i);
        q_last.push_back(1'b1);
`else
        q_last[q_last.size()-1] = 1'b1;
`endif
      end
    end
    @(posedge clk); #1;
    if (q_bit.size() == 0) begin
      chk_val("w_idle", {31'd0, w}, {31'd0, IDLE_LVL});
      chk_val("busy_idle", {31'd0, busy}, 32'd0);
      chk_val("fdone_idle", {31'd0, frame_done}, 32'd0);
    end else begin
      chk_val("w_bit", {31'd0, w}, {31'd0, q_bit[0]});
      chk_val("busy_frame", {31'd0, busy}, 32'd1);
      chk_val("fdone_frame", {31'd0, frame_done}, {31'd0, q_last[0]});
    end
  endtask

  initial begin
    bit acc;
    bit pend_v;
    logic [DATA_W-1:0] pend_d;

    step(1'b1, 1'b0, '0, acc);
    step(1'b1, 1'b1, 8'hFF, acc);

    // Single word, then idle long enough to drain.
    step(1'b0, 1'b1, 8'hA5, acc);
    chk_val("accept_a5", {31'd0, acc}, 32'd1);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, '0, acc);

    // Back-to-back A5 then 3C with valid held, plus backpressured FF.
    pend_v = 1'b1; pend_d = 8'hA5;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, pend_v, pend_d, acc);
      if (acc) begin
        if (pend_d == 8'hA5) pend_d = 8'h3C;
        else if (pend_d == 8'h3C) pend_d = 8'hFF;
        else pend_v = 1'b0;
      end
    end

    // Reset mid-frame, then immediate new word.
    step(1'b0, 1'b1, 8'hA5, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, acc);
    step(1'b1, 1'b0, '0, acc);
    step(1'b0, 1'b1, 8'h81, acc);
    chk_val("accept_81", {31'd0, acc}, 32'd1);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, '0, acc);

    // Randomized traffic with held data and occasional reset.
    pend_v = 1'b0; pend_d = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!pend_v && ($urandom_range(0, 3) != 0)) begin
        pend_v = 1'b1;
        pend_d = DATA_W'($urandom);
      end
      step(($urandom_range(0, 49) == 0), pend_v, pend_d, acc);
      if (acc) pend_v = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
